mem_stage: RTL and testbench

Memory-access stage that consumes the execute stage's registered outputs (result, effective address, store data, destination register) and presents one writeback record per instruction. Loads and stores go to the data cache over a valid/ready request channel plus a response channel. The stage aligns load data from the returned doubleword and sign- or zero-extends it. Non-memory results pass through. The stage backpressures execute while a memory access is outstanding.

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/mem_stage_load_align.sv | 29 ++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage: access sizes, FSM
// states, and the byte-lane mask and alignment rules.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2
    } ms_state_e;

    function automatic logic [3:0] size_bytes(input mem_size_e size);
        case (size)
            MEM_B:   size_bytes = 4'd1;
            MEM_H:   size_bytes = 4'd2;
            MEM_W:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

    function automatic logic misaligned(input mem_size_e size, input logic [2:0] off);
        case (size)
            MEM_B:   misaligned = 1'b0;
            MEM_H:   misaligned = off[0];
            MEM_W:   misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
    endfunction

    // Nine bits so a doubleword mask (1<<8)-1 comes out as 8'hFF.
    function automatic logic [7:0] byte_mask(input mem_size_e size, input logic [2:0] off);
        logic [8:0] mask;
        mask      = (9'd1 << size_bytes(size)) - 9'd1;
        byte_mask = mask[7:0] << off;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed lane of the returned doubleword
// and sign- or zero-extends it to XLEN.
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      off_i,
    input  mem_size_e       size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] lane_o
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        lane_o = shifted;
        case (size_i)
            MEM_B:   lane_o = {{(XLEN-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
            MEM_H:   lane_o = {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
            MEM_W:   lane_o = {{(XLEN-32){~unsigned_i & shifted[31]}}, shifted[31:0]};
            default: lane_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, issues one aligned cache
// access at a time for loads/stores, and emits one writeback pulse per record.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [4:0]        ex_rd,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [XLEN-1:0]   req_wdata,
    output logic [7:0]        req_wstrb,
    input  logic              resp_valid,
    input  logic [XLEN-1:0]   resp_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              misalign
);

    // state   | meaning
    // IDLE    | ready for a record; ALU results and misaligned accesses retire here
    // REQ     | cache request presented, held stable until req_ready
    // WAIT    | request accepted, waiting for resp_valid

    ms_state_e         state_q;
    logic [2:0]        off_q;
    mem_size_e         size_q;
    logic              unsigned_q;
    logic              is_load_q;
    logic [4:0]        rd_q;

    logic              req_valid_q, req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [XLEN-1:0]   req_wdata_q;
    logic [7:0]        req_wstrb_q;
    logic              wb_valid_q, wb_we_q, misalign_q;
    logic [4:0]        wb_rd_q;
    logic [XLEN-1:0]   wb_data_q;

    logic              accept;
    logic              is_mem;
    logic              mis_d;
    logic [2:0]        off_d;
    mem_size_e         size_d;
    logic [XLEN-1:0]   wdata_d;
    logic [7:0]        wstrb_d;
    logic [XLEN-1:0]   lane_d;

    assign ex_ready = (state_q == MS_IDLE) && !reset;
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_is_load || ex_is_store;
    assign off_d    = ex_addr[2:0];
    assign size_d   = mem_size_e'(ex_size);
    assign mis_d    = misaligned(size_d, off_d);
    assign wdata_d  = ex_wdata << {off_d, 3'b000};
    assign wstrb_d  = ex_is_store ? byte_mask(size_d, off_d) : 8'h00;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i    (resp_rdata),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .lane_o     (lane_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MS_IDLE;
            off_q       <= 3'd0;
            size_q      <= MEM_B;
            unsigned_q  <= 1'b0;
            is_load_q   <= 1'b0;
            rd_q        <= 5'd0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= 8'h00;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= '0;
            misalign_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                MS_IDLE: begin
                    if (accept && !is_mem) begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= (ex_rd != 5'd0);
                        wb_rd_q    <= ex_rd;
                        wb_data_q  <= ex_result;
                    end else if (accept && mis_d) begin
                        misalign_q <= 1'b1;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= ex_rd;
                        wb_data_q  <= '0;
                    end else if (accept) begin
                        off_q       <= off_d;
                        size_q      <= size_d;
                        unsigned_q  <= ex_unsigned;
                        rd_q        <= ex_rd;
                        // load+store together behaves as a store
                        is_load_q   <= ex_is_load && !ex_is_store;
                        req_valid_q <= 1'b1;
                        req_we_q    <= ex_is_store;
                        req_addr_q  <= {ex_addr[ADDR_W-1:3], 3'b000};
                        req_wdata_q <= wdata_d;
                        req_wstrb_q <= wstrb_d;
                        state_q     <= MS_REQ;
                    end
                end
                MS_REQ: begin
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= MS_WAIT;
                    end
                end
                MS_WAIT: begin
                    if (resp_valid) begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= is_load_q && (rd_q != 5'd0);
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= is_load_q ? lane_d : '0;
                        state_q    <= MS_IDLE;
                    end
                end
                default: state_q <= MS_IDLE;
            endcase
        end
    end

    assign req_valid = req_valid_q;
    assign req_we    = req_we_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign req_wstrb = req_wstrb_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed records push expected writebacks,
// a negedge monitor pops and compares every wb_valid pulse.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid, ex_ready, ex_is_load, ex_is_store, ex_unsigned;
    logic [1:0]        ex_size;
    logic [ADDR_W-1:0] ex_addr;
    logic [XLEN-1:0]   ex_wdata, ex_result;
    logic [4:0]        ex_rd;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [7:0]        req_wstrb;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              wb_valid, wb_we, misalign;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;

    mem_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_result(ex_result), .ex_rd(ex_rd),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        mis;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_wb(input logic we, input logic [4:0] rd, input logic [63:0] data,
                             input logic mis);
        wb_exp_t e;
        e.we = we; e.rd = rd; e.data = data; e.mis = mis;
        exp_q.push_back(e);
    endtask

    // Monitor: every writeback pulse must match the oldest expected record.
    always @(negedge clk) begin
        wb_exp_t e;
        if (!reset) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb", 64'(wb_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_misalign", 64'(misalign), 64'(e.mis));
                    chk("wb_we", 64'(wb_we), 64'(e.we));
                    if (!e.mis) begin
                        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                        chk("wb_data", wb_data, e.data);
                    end
                end
            end else if (misalign) begin
                chk("misalign_without_wb", 64'(wb_valid), 64'd1);
            end
        end
    end

    task automatic accept(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] result, input logic [4:0] rd);
        int guard = 0;
        while (!ex_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!ex_ready) chk("ex_ready_timeout", 64'(ex_ready), 64'd1);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_size = sz; ex_unsigned = uns;
        ex_addr = addr; ex_wdata = wdata; ex_result = result; ex_rd = rd;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    endtask

    // One aligned access: stall cycles with req_ready low, request fields
    // checked every REQ cycle, then a response one cycle after the handshake.
    task automatic mem_txn(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                           input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [4:0] rd, input int stall, input logic [63:0] rdata,
                           input logic [63:0] x_addr, input logic [63:0] x_wdata,
                           input logic [7:0] x_strb, input logic x_we, input logic junk);
        req_ready = (stall == 0);
        accept(ld, st, sz, uns, addr, wdata, 64'h0, rd);
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            chk({tag, "_req_valid"}, 64'(req_valid), 64'd1);
            chk({tag, "_req_addr"}, req_addr, x_addr);
            chk({tag, "_req_we"}, 64'(req_we), 64'(x_we));
            chk({tag, "_req_wdata"}, req_wdata, x_wdata);
            chk({tag, "_req_wstrb"}, 64'(req_wstrb), 64'(x_strb));
            chk({tag, "_ex_ready_req"}, 64'(ex_ready), 64'd0);
            if (i == stall) begin
                req_ready = 1'b1;
                if (junk) begin
                    resp_valid = 1'b1;
                    resp_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
                end
            end
            @(posedge clk); #1;
        end
        req_ready = 1'b0;
        resp_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_req_valid_wait"}, 64'(req_valid), 64'd0);
        chk({tag, "_ex_ready_wait"}, 64'(ex_ready), 64'd0);
        resp_valid = 1'b1;
        resp_rdata = rdata;
        @(posedge clk); #1;
        resp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_size = 2'd0;
        ex_unsigned = 1'b0; ex_addr = '0; ex_wdata = '0; ex_result = '0; ex_rd = 5'd0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_ready", 64'(ex_ready), 64'd0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_req_we", 64'(req_we), 64'd0);
        chk("rst_req_wstrb", 64'(req_wstrb), 64'd0);
        chk("rst_req_addr", req_addr, 64'd0);
        chk("rst_req_wdata", req_wdata, 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_we", 64'(wb_we), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ex_ready_after_reset", 64'(ex_ready), 64'd1);

        // pass-through, including rd=0 which must not write
        expect_wb(1'b1, 5'd5, 64'h1234, 1'b0);
        accept(1'b0, 1'b0, 2'd3, 1'b0, 64'h0, 64'h0, 64'h1234, 5'd5);
        @(negedge clk);
        chk("pt_no_req", 64'(req_valid), 64'd0);
        expect_wb(1'b0, 5'd0, 64'h77, 1'b0);
        accept(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 64'h77, 5'd0);

        // loads
        expect_wb(1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        mem_txn("lb", 1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'h0, 5'd7, 0, 64'h0000_0000_80FF_0000,
                64'h1000, 64'h0, 8'h00, 1'b0, 1'b0);
        expect_wb(1'b1, 5'd8, 64'h0000_0000_0000_BEEF, 1'b0);
        mem_txn("lhu", 1'b1, 1'b0, 2'd1, 1'b1, 64'h2006, 64'h0, 5'd8, 1, 64'hBEEF_0000_0000_0000,
                64'h2000, 64'h0, 8'h00, 1'b0, 1'b1);
        expect_wb(1'b1, 5'd8, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0);
        mem_txn("lh", 1'b1, 1'b0, 2'd1, 1'b0, 64'h2006, 64'h0, 5'd8, 0, 64'hBEEF_0000_0000_0000,
                64'h2000, 64'h0, 8'h00, 1'b0, 1'b0);
        expect_wb(1'b1, 5'd12, 64'h8123_4567_89AB_CDEF, 1'b0);
        mem_txn("ld", 1'b1, 1'b0, 2'd3, 1'b0, 64'h7008, 64'h0, 5'd12, 0, 64'h8123_4567_89AB_CDEF,
                64'h7008, 64'h0, 8'h00, 1'b0, 1'b0);
        expect_wb(1'b1, 5'd13, 64'hFFFF_FFFF_8000_0001, 1'b0);
        mem_txn("lw", 1'b1, 1'b0, 2'd2, 1'b0, 64'h7004, 64'h0, 5'd13, 0, 64'h8000_0001_0000_0000,
                64'h7000, 64'h0, 8'h00, 1'b0, 1'b0);
        expect_wb(1'b0, 5'd0, 64'h0000_0000_8000_0001, 1'b0);
        mem_txn("lwu_r0", 1'b1, 1'b0, 2'd2, 1'b1, 64'h7004, 64'h0, 5'd0, 0, 64'h8000_0001_0000_0000,
                64'h7000, 64'h0, 8'h00, 1'b0, 1'b0);

        // stores
        expect_wb(1'b0, 5'd9, 64'h0, 1'b0);
        mem_txn("sw", 1'b0, 1'b1, 2'd2, 1'b0, 64'h3004, 64'hDEAD_BEEF, 5'd9, 3, 64'h0123_4567_89AB_CDEF,
                64'h3000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1, 1'b0);
        expect_wb(1'b0, 5'd10, 64'h0, 1'b0);
        mem_txn("sb", 1'b0, 1'b1, 2'd0, 1'b0, 64'h5005, 64'hAB, 5'd10, 0, 64'h0,
                64'h5000, 64'h0000_AB00_0000_0000, 8'h20, 1'b1, 1'b0);
        expect_wb(1'b0, 5'd11, 64'h0, 1'b0);
        mem_txn("sd", 1'b0, 1'b1, 2'd3, 1'b0, 64'h6000, 64'h0102_0304_0506_0708, 5'd11, 0, 64'h0,
                64'h6000, 64'h0102_0304_0506_0708, 8'hFF, 1'b1, 1'b0);
        expect_wb(1'b0, 5'd14, 64'h0, 1'b0);
        mem_txn("ldst", 1'b1, 1'b1, 2'd3, 1'b0, 64'h8000, 64'h55AA, 5'd14, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000, 64'h55AA, 8'hFF, 1'b1, 1'b0);

        // misaligned accesses never reach the cache
        expect_wb(1'b0, 5'd3, 64'h0, 1'b1);
        accept(1'b1, 1'b0, 2'd2, 1'b0, 64'h4002, 64'h0, 64'h0, 5'd3);
        expect_wb(1'b0, 5'd4, 64'h0, 1'b1);
        accept(1'b0, 1'b1, 2'd1, 1'b0, 64'h4001, 64'h11, 64'h0, 5'd4);
        @(negedge clk);
        chk("mis_h_no_req", 64'(req_valid), 64'd0);
        expect_wb(1'b0, 5'd6, 64'h0, 1'b1);
        accept(1'b1, 1'b0, 2'd3, 1'b0, 64'h4004, 64'h0, 64'h0, 5'd6);
        @(negedge clk);
        chk("mis_d_no_req", 64'(req_valid), 64'd0);
        @(negedge clk);
        chk("mis_idle_ready", 64'(ex_ready), 64'd1);

        // stray response in IDLE
        resp_valid = 1'b1; resp_rdata = 64'h1;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        @(negedge clk);
        chk("idle_resp_no_wb", 64'(wb_valid), 64'd0);

        // reset while REQ drops the request
        req_ready = 1'b0;
        accept(1'b1, 1'b0, 2'd3, 1'b0, 64'h9000, 64'h0, 64'h0, 5'd15);
        @(negedge clk);
        chk("rreq_req_valid", 64'(req_valid), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rreq_req_dropped", 64'(req_valid), 64'd0);
        chk("rreq_ex_ready", 64'(ex_ready), 64'd1);

        // reset while WAIT: late response is ignored
        req_ready = 1'b1;
        accept(1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'h0, 64'h0, 5'd7);
        @(posedge clk); #1;
        req_ready = 1'b0;
        @(negedge clk);
        chk("rwait_in_wait", 64'(ex_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rwait_ready_in_reset", 64'(ex_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        resp_valid = 1'b1; resp_rdata = 64'h0000_0000_80FF_0000;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        @(negedge clk);
        chk("rwait_no_wb", 64'(wb_valid), 64'd0);
        chk("rwait_ex_ready", 64'(ex_ready), 64'd1);
        expect_wb(1'b1, 5'd21, 64'hCAFE, 1'b0);
        accept(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 64'hCAFE, 5'd21);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
